// File: rtl/pipelined_barrel_shifter.sv
// Two-stage ARM operand-2 shifter with valid/ready flow control and a tag sideband.
// Define SHIFTER_FLAGS_EN to add registered out_zero / out_neg result flags.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 32,
    parameter int AMT_W = $clog2(WIDTH),
    parameter int ROT_W = $clog2(WIDTH) - 1,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [7:0]       in_data_imm,
    input  logic             imm_or_reg,
    input  logic [2:0]       shift_control,
    input  logic [AMT_W-1:0] shift_amt_imm,
    input  logic [WIDTH-1:0] shift_amt_reg,
    input  logic [ROT_W-1:0] rotation_code,
    input  logic             carry_in,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             carry_out,
    output logic [TAG_W-1:0] out_tag
`ifdef SHIFTER_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_neg
`endif
);

    // Amount must be able to hold WIDTH itself as well as any 8-bit register amount.
    localparam int N_W = (AMT_W + 1 > 9) ? AMT_W + 1 : 9;

    typedef enum logic [2:0] {K_PASS, K_LSL, K_LSR, K_ASR, K_ROR, K_RRX} kind_e;

    logic             rdy_q;
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic [N_W-1:0]   s1_n_q, s1_n_d;
    kind_e            s1_kind_q, s1_kind_d;
    logic             s1_cin_q;
    logic [TAG_W-1:0] s1_tag_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q, res_d;
    logic             carry_q, carry_d;
    logic [TAG_W-1:0] out_tag_q;

    logic             s1_adv, s2_adv, accept;
    logic [N_W-1:0]   n_sel;
    logic             unused_amt_hi;

    assign unused_amt_hi = ^shift_amt_reg[WIDTH-1:8];

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = rdy_q && s1_adv;
    assign accept   = in_valid && in_ready;

    // Decode folds every zero-amount special case into a plain kind and amount.
    always_comb begin
        n_sel     = imm_or_reg ? N_W'(shift_amt_imm) : N_W'(shift_amt_reg[7:0]);
        s1_data_d = in_data;
        s1_n_d    = n_sel;
        s1_kind_d = K_PASS;
        case (shift_control)
            3'b000: if (n_sel != '0) s1_kind_d = K_LSL;
            3'b001: begin
                if (n_sel != '0) begin
                    s1_kind_d = K_LSR;
                end else if (imm_or_reg) begin
                    s1_kind_d = K_LSR;
                    s1_n_d    = N_W'(WIDTH);
                end
            end
            3'b010: begin
                if (n_sel != '0) begin
                    s1_kind_d = K_ASR;
                end else if (imm_or_reg) begin
                    s1_kind_d = K_ASR;
                    s1_n_d    = N_W'(WIDTH);
                end
            end
            3'b011: begin
                if (n_sel != '0)     s1_kind_d = K_ROR;
                else if (imm_or_reg) s1_kind_d = K_RRX;
            end
            3'b100: if (n_sel != '0 || imm_or_reg) s1_kind_d = K_RRX;
            3'b101: begin
                s1_data_d = WIDTH'(in_data_imm);
                s1_n_d    = N_W'({rotation_code, 1'b0});
                if (rotation_code != '0) s1_kind_d = K_ROR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_n_q     <= '0;
            s1_kind_q  <= K_PASS;
            s1_cin_q   <= 1'b0;
            s1_tag_q   <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (s1_adv) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_data_q <= s1_data_d;
                    s1_n_q    <= s1_n_d;
                    s1_kind_q <= s1_kind_d;
                    s1_cin_q  <= carry_in;
                    s1_tag_q  <= in_tag;
                end
            end
        end
    end

    // Extra bit beyond the data word catches the last bit shifted out (the carry).
    logic [WIDTH:0]          lsl_w, lsr_w, asr_w;
    logic signed [WIDTH:0]   asr_in;
    logic [N_W-1:0]          asr_n;
    logic [2*WIDTH-1:0]      ror_w;

    assign lsl_w  = {1'b0, s1_data_q} << s1_n_q;
    assign lsr_w  = {s1_data_q, 1'b0} >> s1_n_q;
    assign asr_in = {s1_data_q, 1'b0};
    assign asr_n  = (s1_n_q > N_W'(WIDTH)) ? N_W'(WIDTH) : s1_n_q;
    assign asr_w  = asr_in >>> asr_n;
    assign ror_w  = {s1_data_q, s1_data_q} >> s1_n_q[AMT_W-1:0];

    always_comb begin
        res_d   = s1_data_q;
        carry_d = s1_cin_q;
        case (s1_kind_q)
            K_LSL: begin
                res_d   = lsl_w[WIDTH-1:0];
                carry_d = lsl_w[WIDTH];
            end
            K_LSR: begin
                res_d   = lsr_w[WIDTH:1];
                carry_d = lsr_w[0];
            end
            K_ASR: begin
                res_d   = asr_w[WIDTH:1];
                carry_d = asr_w[0];
            end
            K_ROR: begin
                res_d   = ror_w[WIDTH-1:0];
                carry_d = ror_w[WIDTH-1];
            end
            K_RRX: begin
                res_d   = {s1_cin_q, s1_data_q[WIDTH-1:1]};
                carry_d = s1_data_q[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            carry_q     <= 1'b0;
            out_tag_q   <= '0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q <= res_d;
                carry_q    <= carry_d;
                out_tag_q  <= s1_tag_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign carry_out = carry_q;
    assign out_tag   = out_tag_q;

`ifdef SHIFTER_FLAGS_EN
    logic zero_q, neg_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (s2_adv && s1_valid_q) begin
            zero_q <= (res_d == '0);
            neg_q  <= res_d[WIDTH-1];
        end
    end

    assign out_zero = zero_q;
    assign out_neg  = neg_q;
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: directed ARM shifter cases, back-pressure,
// asynchronous reset with ops in flight, and randomized traffic against a bit-level model.
module tb_pipelined_barrel_shifter;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int RW = 4;
    localparam int TW = 4;
    localparam logic [W-1:0] X = 32'h80000009;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready;
    logic [W-1:0]  in_data;
    logic [7:0]    in_data_imm;
    logic          imm_or_reg;
    logic [2:0]    shift_control;
    logic [AW-1:0] shift_amt_imm;
    logic [W-1:0]  shift_amt_reg;
    logic [RW-1:0] rotation_code;
    logic          carry_in;
    logic [TW-1:0] in_tag;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_data;
    logic          carry_out;
    logic [TW-1:0] out_tag;
`ifdef SHIFTER_FLAGS_EN
    logic          out_zero, out_neg;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(.WIDTH(W), .AMT_W(AW), .ROT_W(RW), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_data_imm(in_data_imm), .imm_or_reg(imm_or_reg),
        .shift_control(shift_control), .shift_amt_imm(shift_amt_imm),
        .shift_amt_reg(shift_amt_reg), .rotation_code(rotation_code),
        .carry_in(carry_in), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .carry_out(carry_out), .out_tag(out_tag)
`ifdef SHIFTER_FLAGS_EN
        , .out_zero(out_zero), .out_neg(out_neg)
`endif
    );

    typedef struct {
        logic [W-1:0]  data;
        logic [7:0]    imm;
        logic          ior;
        logic [2:0]    ctrl;
        logic [AW-1:0] ai;
        logic [W-1:0]  ar;
        logic [RW-1:0] rot;
        logic          cin;
        logic [TW-1:0] tag;
    } op_t;

    typedef struct {
        logic [W-1:0]  data;
        logic          c;
        logic [TW-1:0] tag;
    } res_t;

    typedef struct {
        logic [W-1:0]  d;
        logic [7:0]    imm;
        logic          ior;
        logic [2:0]    ctrl;
        logic [AW-1:0] ai;
        logic [W-1:0]  ar;
        logic [RW-1:0] rot;
        logic          cin;
        logic [W-1:0]  ed;
        logic          ec;
    } dir_t;

    // Reference model: evaluates the shift rules bit by bit with integer arithmetic.
    function automatic res_t ref_model(input op_t o);
        res_t r;
        int n, kind, m, sh;
        logic [W-1:0] d, y, iw;
        logic c;
        d = o.data; y = d; c = o.cin;
        n = o.ior ? int'(o.ai) : int'(o.ar[7:0]);
        kind = int'(o.ctrl);
        if (o.ctrl == 3'd5) begin
            sh = 2 * int'(o.rot);
            iw = W'(o.imm);
            for (int i = 0; i < W; i++) y[i] = iw[(i + sh) % W];
            c = (o.rot == '0) ? o.cin : y[W-1];
        end else if (o.ctrl > 3'd5 || (!o.ior && n == 0)) begin
            y = d; c = o.cin;
        end else begin
            if (o.ior && n == 0) begin
                case (kind)
                    0: kind = 7;
                    1, 2: n = W;
                    3: kind = 4;
                    default: ;
                endcase
            end
            case (kind)
                0: begin
                    for (int i = 0; i < W; i++) y[i] = (i >= n) ? d[i-n] : 1'b0;
                    c = (n <= W) ? d[W-n] : 1'b0;
                end
                1: begin
                    for (int i = 0; i < W; i++) y[i] = (i + n < W) ? d[i+n] : 1'b0;
                    c = (n <= W) ? d[n-1] : 1'b0;
                end
                2: begin
                    for (int i = 0; i < W; i++) y[i] = (i + n < W) ? d[i+n] : d[W-1];
                    c = (n < W) ? d[n-1] : d[W-1];
                end
                3: begin
                    m = n % W;
                    for (int i = 0; i < W; i++) y[i] = d[(i + m) % W];
                    c = y[W-1];
                end
                4: begin
                    y = {o.cin, d[W-1:1]};
                    c = d[0];
                end
                default: begin
                    y = d; c = o.cin;
                end
            endcase
        end
        r.data = y; r.c = c; r.tag = o.tag;
        return r;
    endfunction

    function automatic op_t rand_op(input logic [TW-1:0] tag);
        op_t o;
        o.data = $urandom;
        if ($urandom_range(0, 7) == 0) o.data = '0;
        o.imm  = 8'($urandom);
        o.ior  = 1'($urandom);
        o.ctrl = 3'($urandom);
        o.ai   = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
        o.ar   = $urandom;
        if ($urandom_range(0, 1) == 1) o.ar[7:0] = 8'($urandom_range(0, 40));
        o.rot  = RW'($urandom);
        o.cin  = 1'($urandom);
        o.tag  = tag;
        return o;
    endfunction

    task automatic drive(input op_t o, input logic v);
        in_valid      = v;
        in_data       = o.data;
        in_data_imm   = o.imm;
        imm_or_reg    = o.ior;
        shift_control = o.ctrl;
        shift_amt_imm = o.ai;
        shift_amt_reg = o.ar;
        rotation_code = o.rot;
        carry_in      = o.cin;
        in_tag        = o.tag;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #2;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== '0 || carry_out !== 1'b0 || out_tag !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b ready=%b data=%h c=%b tag=%h, want all 0",
                     out_valid, in_ready, out_data, carry_out, out_tag);
        end
        #1 reset = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_before_edge: got in_ready=%b, want 0", in_ready);
        end
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_edge: got in_ready=%b, want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        dir_t tbl[16];
        op_t  o;
        tbl[0]  = '{X, 8'h00, 1'b1, 3'd0, 5'd1,  32'd0,     4'd0, 1'b0, 32'h00000012, 1'b1};
        tbl[1]  = '{X, 8'h00, 1'b1, 3'd1, 5'd1,  32'd0,     4'd0, 1'b0, 32'h40000004, 1'b1};
        tbl[2]  = '{X, 8'h00, 1'b1, 3'd2, 5'd4,  32'd0,     4'd0, 1'b0, 32'hF8000000, 1'b1};
        tbl[3]  = '{X, 8'h00, 1'b1, 3'd3, 5'd0,  32'd0,     4'd0, 1'b1, 32'hC0000004, 1'b1};
        tbl[4]  = '{X, 8'hB8, 1'b0, 3'd5, 5'd0,  32'd0,     4'd1, 1'b0, 32'h0000002E, 1'b0};
        tbl[5]  = '{X, 8'hB8, 1'b1, 3'd5, 5'd7,  32'd0,     4'd0, 1'b1, 32'h000000B8, 1'b1};
        tbl[6]  = '{X, 8'h00, 1'b0, 3'd0, 5'd0,  32'd40,    4'd0, 1'b0, 32'h00000000, 1'b0};
        tbl[7]  = '{X, 8'h00, 1'b0, 3'd1, 5'd0,  32'd32,    4'd0, 1'b0, 32'h00000000, 1'b1};
        tbl[8]  = '{X, 8'h00, 1'b0, 3'd2, 5'd0,  32'd200,   4'd0, 1'b0, 32'hFFFFFFFF, 1'b1};
        tbl[9]  = '{X, 8'h00, 1'b0, 3'd3, 5'd0,  32'd32,    4'd0, 1'b0, X,            1'b1};
        tbl[10] = '{X, 8'h00, 1'b0, 3'd0, 5'd0,  32'd0,     4'd0, 1'b1, X,            1'b1};
        tbl[11] = '{X, 8'h00, 1'b1, 3'd1, 5'd0,  32'd0,     4'd0, 1'b0, 32'h00000000, 1'b1};
        tbl[12] = '{X, 8'h00, 1'b0, 3'd1, 5'd0,  32'h100,   4'd0, 1'b0, X,            1'b0};
        tbl[13] = '{32'h12345678, 8'h00, 1'b1, 3'd6, 5'd3, 32'd0, 4'd0, 1'b1, 32'h12345678, 1'b1};
        tbl[14] = '{X, 8'h00, 1'b0, 3'd0, 5'd0,  32'd32,    4'd0, 1'b0, 32'h00000000, 1'b1};
        tbl[15] = '{32'h40000000, 8'h00, 1'b1, 3'd2, 5'd31, 32'd0, 4'd0, 1'b0, 32'h00000000, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            o.data = tbl[i].d;   o.imm = tbl[i].imm; o.ior = tbl[i].ior; o.ctrl = tbl[i].ctrl;
            o.ai   = tbl[i].ai;  o.ar  = tbl[i].ar;  o.rot = tbl[i].rot; o.cin  = tbl[i].cin;
            o.tag  = TW'(i);
            drive(o, 1'b1);
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL dir%0d_accept: got in_ready=%b, want 1", i, in_ready);
            end
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL dir%0d_early: got out_valid=%b one cycle after accept, want 0", i, out_valid);
            end
            tick();
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_data !== tbl[i].ed || carry_out !== tbl[i].ec || out_tag !== TW'(i)) begin
                miscompares++;
                $display("FAIL dir%0d_result: got v=%b data=%h c=%b tag=%h, want v=1 data=%h c=%b tag=%h",
                         i, out_valid, out_data, carry_out, out_tag, tbl[i].ed, tbl[i].ec, TW'(i));
            end
            tick();
        end
    endtask

    task automatic test_back_pressure();
        op_t  ops[3];
        res_t ex[3];
        int   acc, got;
        logic [W-1:0]  d_s;
        logic          c_s;
        logic [TW-1:0] t_s;
        for (int k = 0; k < 3; k++) begin
            ops[k] = rand_op(TW'(k + 1));
            ex[k]  = ref_model(ops[k]);
        end
        acc = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            drive(ops[acc], 1'b1);
            @(negedge clk);
            if (in_ready === 1'b1) acc++;
            tick();
        end
        drive(ops[acc > 2 ? 2 : acc], 1'b1);
        @(negedge clk);
        vectors++;
        if (acc != 2 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_accept: got accepted=%0d in_ready=%b, want accepted=2 in_ready=0", acc, in_ready);
        end
        vectors++;
        if (out_valid !== 1'b1 || out_tag !== 4'd1) begin
            miscompares++;
            $display("FAIL bp_head: got out_valid=%b tag=%h, want 1 tag=1", out_valid, out_tag);
        end
        d_s = out_data; c_s = carry_out; t_s = out_tag;
        for (int cyc = 0; cyc < 3; cyc++) begin
            tick();
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_data !== d_s || carry_out !== c_s || out_tag !== t_s || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold: got v=%b data=%h c=%b tag=%h rdy=%b, want v=1 data=%h c=%b tag=%h rdy=0",
                         out_valid, out_data, carry_out, out_tag, in_ready, d_s, c_s, t_s);
            end
        end
        tick();
        out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                vectors++;
                if (out_data !== ex[got].data || carry_out !== ex[got].c || out_tag !== ex[got].tag) begin
                    miscompares++;
                    $display("FAIL bp_drain%0d: got data=%h c=%b tag=%h, want data=%h c=%b tag=%h",
                             got, out_data, carry_out, out_tag, ex[got].data, ex[got].c, ex[got].tag);
                end
                got++;
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) acc++;
            tick();
            if (acc >= 3) in_valid = 1'b0;
        end
        @(negedge clk);
        vectors++;
        if (got != 3 || acc != 3 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_count: got results=%0d accepted=%0d trailing_valid=%b, want 3 3 0", got, acc, out_valid);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        op_t  a, b, c;
        res_t ec;
        int   acc;
        a = rand_op(4'hA); b = rand_op(4'hB); c = rand_op(4'hC);
        ec = ref_model(c);
        acc = 0;
        out_ready = 1'b0;
        drive(a, 1'b1);
        @(negedge clk);
        if (in_ready === 1'b1) acc++;
        tick();
        drive(b, 1'b1);
        @(negedge clk);
        if (in_ready === 1'b1) acc++;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (acc != 2) begin
            miscompares++;
            $display("FAIL mid_fill: got accepted=%0d, want 2", acc);
        end
        #1 reset = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== '0 || carry_out !== 1'b0 || out_tag !== '0) begin
            miscompares++;
            $display("FAIL mid_async_reset: got v=%b rdy=%b data=%h c=%b tag=%h, want all 0",
                     out_valid, in_ready, out_data, carry_out, out_tag);
        end
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        out_ready = 1'b1;
        tick();
        drive(c, 1'b1);
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_restart: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_early: got out_valid=%b, want 0", out_valid);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== ec.data || carry_out !== ec.c || out_tag !== ec.tag) begin
            miscompares++;
            $display("FAIL mid_result: got v=%b data=%h c=%b tag=%h, want v=1 data=%h c=%b tag=%h",
                     out_valid, out_data, carry_out, out_tag, ec.data, ec.c, ec.tag);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_stale: got out_valid=%b after the only new op, want 0", out_valid);
        end
        tick();
    endtask

    task automatic test_random();
        res_t q[$];
        res_t e;
        op_t  o;
        logic          stall_prev;
        logic [W-1:0]  d_prev;
        logic          c_prev;
        logic [TW-1:0] t_prev;
        logic [TW-1:0] tagc;
        stall_prev = 1'b0; d_prev = '0; c_prev = 1'b0; t_prev = '0; tagc = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            o = rand_op(tagc);
            drive(o, ($urandom_range(0, 9) < 7));
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (stall_prev) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== d_prev || carry_out !== c_prev || out_tag !== t_prev) begin
                    miscompares++;
                    $display("FAIL rnd_hold: got v=%b data=%h c=%b tag=%h, want v=1 data=%h c=%b tag=%h",
                             out_valid, out_data, carry_out, out_tag, d_prev, c_prev, t_prev);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rnd_spurious: got output tag=%h, want none pending", out_tag);
                end else begin
                    e = q.pop_front();
                    if (out_data !== e.data || carry_out !== e.c || out_tag !== e.tag) begin
                        miscompares++;
                        $display("FAIL rnd_result: got data=%h c=%b tag=%h, want data=%h c=%b tag=%h",
                                 out_data, carry_out, out_tag, e.data, e.c, e.tag);
                    end
`ifdef SHIFTER_FLAGS_EN
                    vectors++;
                    if (out_zero !== (e.data == '0) || out_neg !== e.data[W-1]) begin
                        miscompares++;
                        $display("FAIL rnd_flags: got z=%b n=%b, want z=%b n=%b",
                                 out_zero, out_neg, (e.data == '0), e.data[W-1]);
                    end
`endif
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                q.push_back(ref_model(o));
                tagc++;
            end
            vectors++;
            if (q.size() > 2) begin
                miscompares++;
                $display("FAIL rnd_inflight: got %0d ops in flight, want at most 2", q.size());
            end
            stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0);
            d_prev = out_data; c_prev = carry_out; t_prev = out_tag;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && q.size() > 0; cyc++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                e = q.pop_front();
                vectors++;
                if (out_data !== e.data || carry_out !== e.c || out_tag !== e.tag) begin
                    miscompares++;
                    $display("FAIL rnd_drain: got data=%h c=%b tag=%h, want data=%h c=%b tag=%h",
                             out_data, carry_out, out_tag, e.data, e.c, e.tag);
                end
            end
            tick();
        end
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL rnd_timeout: got %0d results still pending, want 0", q.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_data = '0; in_data_imm = '0; imm_or_reg = 1'b0;
        shift_control = '0; shift_amt_imm = '0; shift_amt_reg = '0; rotation_code = '0;
        carry_in = 1'b0; in_tag = '0; out_ready = 1'b1;
        test_reset();
        test_directed();
        test_back_pressure();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        miscompares++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, two-stage pipelined ARM-style operand-2 shifter. It replaces the single-cycle enable-strobed shifter for the execute stage.
- Supports LSL/LSR/ASR/ROR/RRX and rotated-immediate generation with ARM carry-out semantics.
- Adds WIDTH generalisation, valid/ready flow control with back-pressure, and a passthrough tag, so it can sit between the decode/register-read and ALU stages.

Parameters:
WIDTH, 32, datapath width; power of two, >= 8
AMT_W, $clog2(WIDTH), immediate shift-amount width
ROT_W, $clog2(WIDTH)-1, rotation-code width (immediate rotated right by 2*rot)
TAG_W, 4, sideband tag carried alongside each operation

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  shifter can accept a request this cycle
in_data  input  WIDTH  register operand to shift
in_data_imm  input  8  immediate byte (rotate-immediate op)
imm_or_reg  input  1  1 = amount from shift_amt_imm, 0 = from shift_amt_reg[7:0]
shift_control  input  3  000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX, 101 ROT_IMM, others = pass (MOV)
shift_amt_imm  input  AMT_W  immediate shift amount
shift_amt_reg  input  WIDTH  register shift amount; only bits [7:0] are used
rotation_code  input  ROT_W  rotate-immediate code
carry_in  input  1  current C flag
in_tag  input  TAG_W  sideband tag
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_data  output  WIDTH  shifted result
carry_out  output  1  shifter carry
out_tag  output  TAG_W  tag of the result

Behaviour:
- Reset: this block uses one clock, clk, and an asynchronous active-high reset, reset. While reset is asserted, both stage valids clear, out_valid=0, out_data=0, carry_out=0, out_tag=0 and in_ready=0. in_ready rises on the first clk edge after reset deasserts.
- Handshake:
  - A transfer occurs on a clk edge where valid && ready.
  - Stage S1 registers the decoded op (data, n, op kind, carry_in, tag).
  - Stage S2 registers the result and drives out_*.
  - Latency is exactly 2 cycles from input acceptance to out_valid with no stall.
  - Full throughput is 1 op per cycle.
- Stall rules:
  - S2 advances when !s2_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready = S1 advances (combinational from out_ready).
  - At most 2 ops are in flight.
  - out_* hold stable while out_valid && !out_ready.
- Amount selection: n = imm_or_reg ? zero-extended shift_amt_imm : shift_amt_reg[7:0].
- Immediate-zero special cases (imm_or_reg=1, n=0):
  - LSR#0 means LSR#WIDTH.
  - ASR#0 means ASR#WIDTH.
  - ROR#0 means RRX.
  - LSL#0 passes the data unchanged with carry=carry_in.
- Register amount n=0: any op passes in_data unchanged with carry=carry_in.
- LSL:
  - 0<n<WIDTH: carry = in[WIDTH-n].
  - n==WIDTH: result 0, carry = in[0].
  - n>WIDTH: result 0, carry 0.
- LSR:
  - 0<n<WIDTH: carry = in[n-1].
  - n==WIDTH: result 0, carry = in[WIDTH-1].
  - n>WIDTH: result 0, carry 0.
- ASR:
  - 0<n<WIDTH: carry = in[n-1].
  - n>=WIDTH: result is all copies of in[WIDTH-1], carry = in[WIDTH-1].
- ROR (n != 0): rotate by n mod WIDTH, carry = result[WIDTH-1]. If n mod WIDTH == 0, data is unchanged and carry = in[WIDTH-1].
- RRX: result = {carry_in, in[WIDTH-1:1]}, carry = in[0].
- ROT_IMM:
  - Result = zero-extended in_data_imm rotated right by 2*rotation_code.
  - carry = rotation_code==0 ? carry_in : result[WIDTH-1].
  - imm_or_reg is ignored for this op.
- Undefined op codes 110 and 111: pass in_data unchanged, carry=carry_in.
- carry_in is sampled at acceptance; later flag changes do not affect in-flight ops.
- Reset mid-operation: all in-flight ops are discarded and no output is produced for them.

Optional Feature:
SHIFTER_FLAGS_EN
- Defined: adds output ports out_zero (out_data==0) and out_neg (out_data[WIDTH-1]). Both are registered in S2 alongside out_data, reset to 0, and held during a stall.
- Undefined: these ports and their logic are absent.

Test Plan:
- LSL imm#1, in=0x80000009, carry_in=0 -> after 2 cycles out_data=0x00000012, carry_out=1. Repeat with LSR imm#1 -> 0x40000004, carry_out=1.
- ASR imm#4, in=0x80000009 -> 0xF8000000, carry_out=1. ROR imm#0 with carry_in=1 (RRX) -> 0xC0000004, carry_out=1.
- ROT_IMM in_data_imm=0xB8: rotation_code=1 -> 0x0000002E, carry_out=0. rotation_code=0 with carry_in=1 -> 0x000000B8, carry_out=1.
- Register amounts, in=0x80000009: LSL 40 -> 0, carry 0. LSR 32 -> 0, carry 1. ASR 200 -> 0xFFFFFFFF, carry 1. ROR 32 -> unchanged, carry 1. amount 0 with carry_in=1 -> unchanged, carry 1.
- Back-pressure: out_ready=0, offer 3 back-to-back ops tagged 1, 2, 3 -> only 2 accepted, in_ready=0, out_* stable. Raise out_ready -> results emerge in tag order 1, 2, 3 with no loss or duplication.
- Assert reset with 2 ops in flight -> out_valid=0 immediately (asynchronous). After release, the first new op appears exactly 2 cycles after acceptance.
